axis_vga_out: RTL
=================

Name: axis_vga_out

Overview:
- Parametrised AXI4-Stream to VGA scan-out stage. Sits between the frame-buffer DMA stream and the board VGA pins.
- Generates programmable raster timing with configurable sync polarity and colour depth.
- Locks to the stream using the start-of-frame flag (tuser). Checks end-of-line (tlast) placement.
- Tolerates underflow by substituting black and counting the event. It never stalls the raster.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync (0 = active-low)
- COLOR_BITS, 1, output bits per colour channel (1..8)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous reset, active-high
- s_axis_tdata  in  32  pixel {8'hx, R[23:16], G[15:8], B[7:0]}
- s_axis_tvalid  in  1  pixel valid
- s_axis_tlast  in  1  last pixel of line
- s_axis_tuser  in  1  first pixel of frame
- s_axis_tready  out  1  pixel accept
- err_clear  in  1  single-cycle pulse; clears sticky flags and the counter
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  display enable (active pixel)
- vga_r  out  COLOR_BITS  red, tdata[23 -: COLOR_BITS]
- vga_g  out  COLOR_BITS  green, tdata[15 -: COLOR_BITS]
- vga_b  out  COLOR_BITS  blue, tdata[7 -: COLOR_BITS]
- locked  out  1  stream aligned to raster
- frame_start  out  1  one-cycle pulse when raster position (0,0) is output
- underflow_sticky  out  1  an active pixel had no data
- sof_err_sticky  out  1  tuser arrived at the wrong position, or was missing at (0,0)
- eol_err_sticky  out  1  tlast was misplaced
- underflow_count  out  16  saturating count of underflowed pixels

Behaviour:
- Totals and widths:
  - H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
  - h_cnt/v_cnt width is $clog2(total).
- Counters: h_cnt wraps at H_TOTAL-1 and then increments v_cnt. v_cnt wraps at V_TOTAL-1.
- active = h_cnt < H_VISIBLE && v_cnt < V_VISIBLE.
- Sync generation:
  - hsync is asserted for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC).
  - vsync uses the same rule on v_cnt.
  - Both are driven at the asserted level given by the POL parameters.
- Latency: every output is registered. Sync, de, colour and frame_start reflect the counter position of the previous cycle (1-cycle latency). Sync and colour stay aligned.
- Reset behaviour:
  - Counters = 0, state = WAIT_SOF.
  - de = 0, colours = 0, hsync/vsync = deasserted level.
  - locked = 0, frame_start = 0, all sticky flags = 0, underflow_count = 0.
- State WAIT_SOF:
  - Counters free-run; syncs are generated; de and colours are 0.
  - tready = 1. Beats with tuser = 0 are discarded.
  - An accepted beat with tuser = 1 is treated as pixel (0,0):
    - the next cycle outputs it with de = 1 and frame_start = 1;
    - counters jump to (1,0);
    - state goes to RUN; locked = 1.
  - A sync glitch at this jump is permitted.
- State RUN:
  - tready = active.
  - Active position with tvalid = 1: the beat is consumed and its colour is output next cycle.
  - Active position with tvalid = 0 (underflow):
    - black is output with de = 1;
    - underflow_sticky is set and underflow_count increments (saturates at 16'hFFFF);
    - the slot is skipped and the raster is never stalled.
  - Blanking: tready = 0 and colours = 0.
- SOF check, applied to accepted beats in RUN:
  - tuser = 1 at a position other than (0,0): sof_err_sticky is set, the beat becomes pixel (0,0), counters jump to (1,0), and frame_start pulses. Lock is kept.
  - tuser = 0 at (0,0): sof_err_sticky is set, the beat is output, and state goes to WAIT_SOF with locked = 0.
- EOL check, applied to accepted beats in RUN:
  - tlast must equal (h_cnt == H_VISIBLE-1). Any mismatch sets eol_err_sticky.
  - No realignment is performed.
- err_clear:
  - Clears the three sticky flags and underflow_count.
  - If it coincides with a setting event, the set wins (the flag ends at 1; the counter ends at 1).
- Reset asserted mid-frame behaves identically to reset at power-up. No stream beat is accepted while reset = 1 (tready = 0).

Test Plan:
- Small timing for all tests: H = 8/2/2/2 (H_TOTAL = 14), V = 4/1/1/1 (V_TOTAL = 7), COLOR_BITS = 8.
- Reset, then 3 idle frames with no stream -> hsync low for exactly 2 of every 14 clocks, vsync low for 1 line in 7, de = 0, locked = 0, tready = 1.
- Stream pixels 32'h00RRGGBB = index 0..31 with tuser on the first and tlast every 8th -> locked = 1. Output colours equal the index, in raster order, 1 cycle after acceptance. frame_start pulses once per 98 clocks. No sticky flags set.
- After lock, hold tvalid = 0 for 3 active pixels -> those 3 pixels are black with de = 1, underflow_count = 3, underflow_sticky = 1. The raster period is unchanged.
- Assert tuser on pixel (5,2) -> sof_err_sticky = 1, that beat is output as pixel (0,0), frame_start pulses, locked stays 1.
- Send tlast on pixel index 6 of a line -> eol_err_sticky = 1. Then pulse err_clear in the same cycle as an underflow -> eol_err_sticky = 0, underflow_count = 1.
- Assert reset mid-frame while locked -> on the next cycle all outputs are at reset values and locked = 0. Relock occurs on the next tuser beat.

Source files
------------

// File: rtl/axis_vga_out.sv
// AXI4-Stream to VGA scan-out stage: programmable raster timing, stream lock on
// tuser, tlast placement checking, and black substitution on underflow.
module axis_vga_out #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  input  logic                  err_clear,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [COLOR_BITS-1:0] vga_r,
  output logic [COLOR_BITS-1:0] vga_g,
  output logic [COLOR_BITS-1:0] vga_b,
  output logic                  locked,
  output logic                  frame_start,
  output logic                  underflow_sticky,
  output logic                  sof_err_sticky,
  output logic                  eol_err_sticky,
  output logic [15:0]           underflow_count
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  typedef enum logic {
    WAIT_SOF,
    RUN
  } state_t;

  state_t state, state_next;

  logic [H_W-1:0] h_cnt, h_eff, h_next;
  logic [V_W-1:0] v_cnt, v_eff, v_next;

  logic active, at_origin, accept;
  logic realign, pixel_out, underflow, sof_err, eol_err, eol_expected;
  logic hs_next, vs_next, de_next, fs_next;
  logic [COLOR_BITS-1:0] r_next, g_next, b_next;
  logic unused_tdata;

  assign active        = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);
  assign at_origin     = (h_cnt == '0) && (v_cnt == '0);
  assign s_axis_tready = !reset && ((state == WAIT_SOF) || active);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign locked        = (state == RUN);
  assign unused_tdata  = &{1'b0, s_axis_tdata[31:24]};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    realign    = 1'b0;
    pixel_out  = 1'b0;
    underflow  = 1'b0;
    sof_err    = 1'b0;

    case (state)
      WAIT_SOF: begin
        if (accept && s_axis_tuser) begin
          realign    = 1'b1;
          pixel_out  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (active) begin
          if (!accept) begin
            underflow = 1'b1;
          end else begin
            pixel_out = 1'b1;
            if (s_axis_tuser && !at_origin) begin
              realign = 1'b1;
              sof_err = 1'b1;
            end else if (!s_axis_tuser && at_origin) begin
              sof_err    = 1'b1;
              state_next = WAIT_SOF;
            end
          end
        end
      end
    endcase

    // A start-of-frame beat redefines the current slot as raster (0,0).
    h_eff = realign ? '0 : h_cnt;
    v_eff = realign ? '0 : v_cnt;

    if (h_eff == H_LAST) begin
      h_next = '0;
      v_next = (v_eff == V_LAST) ? '0 : v_eff + V_W'(1);
    end else begin
      h_next = h_eff + H_W'(1);
      v_next = v_eff;
    end

    eol_expected = (int'(h_eff) == H_VISIBLE - 1);
    eol_err      = (state == RUN) && pixel_out && (s_axis_tlast != eol_expected);

    hs_next = (int'(h_eff) >= HS_START && int'(h_eff) < HS_END) ? HSYNC_POL : !HSYNC_POL;
    vs_next = (int'(v_eff) >= VS_START && int'(v_eff) < VS_END) ? VSYNC_POL : !VSYNC_POL;

    de_next = pixel_out || underflow;
    fs_next = de_next && (h_eff == '0) && (v_eff == '0);
    r_next  = pixel_out ? s_axis_tdata[23 -: COLOR_BITS] : '0;
    g_next  = pixel_out ? s_axis_tdata[15 -: COLOR_BITS] : '0;
    b_next  = pixel_out ? s_axis_tdata[7 -: COLOR_BITS]  : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state            <= WAIT_SOF;
      h_cnt            <= '0;
      v_cnt            <= '0;
      hsync            <= !HSYNC_POL;
      vsync            <= !VSYNC_POL;
      de               <= 1'b0;
      frame_start      <= 1'b0;
      vga_r            <= '0;
      vga_g            <= '0;
      vga_b            <= '0;
      underflow_sticky <= 1'b0;
      sof_err_sticky   <= 1'b0;
      eol_err_sticky   <= 1'b0;
      underflow_count  <= '0;
    end else begin
      state       <= state_next;
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      de          <= de_next;
      frame_start <= fs_next;
      vga_r       <= r_next;
      vga_g       <= g_next;
      vga_b       <= b_next;

      // A set event in the same cycle as err_clear wins.
      underflow_sticky <= underflow || (underflow_sticky && !err_clear);
      sof_err_sticky   <= sof_err   || (sof_err_sticky   && !err_clear);
      eol_err_sticky   <= eol_err   || (eol_err_sticky   && !err_clear);

      if (err_clear) begin
        underflow_count <= {15'd0, underflow};
      end else if (underflow && (underflow_count != 16'hFFFF)) begin
        underflow_count <= underflow_count + 16'd1;
      end
    end
  end

endmodule
